stream_mux_rr: RTL

Parametrised N:1 stream multiplexer: the next generation of the team's 4:1 combinational mux. It adds valid/ready handshaking per channel, a registered output stage and two selection modes: external select or round-robin. Packet-aware locking keeps multi-beat packets contiguous. It sits between several producer streams and one shared consumer.

---
 rtl/stream_mux_pkg.sv | 17 +
 rtl/stream_mux_rr_rr_arbiter.sv | 36 +++
 rtl/stream_mux_rr.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_PKT  = 1'b1
  } lock_state_e;

  // A single channel still needs a 1-bit select/channel field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_rr_arbiter.sv
// Round-robin grant for the stream mux: the search starts just above the
// pointer, and an open packet pins the grant to its channel.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   pointer,
  input  logic              lock_en,
  input  logic [CH_W-1:0]   lock_ch,
  output logic [NUM_CH-1:0] gnt
);

  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    if (lock_en) begin
      if (req[lock_ch]) gnt[lock_ch] = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = CH_W'((int'(pointer) + i) % NUM_CH);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with registered output, external-select or
// round-robin arbitration, and packet locking.
//
// state   | meaning
// LK_OPEN | no packet in flight, any channel may be granted
// LK_PKT  | packet open on lock_ch, only that channel is granted until last
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 4,
  parameter  int MODE   = 1,
  localparam int CH_W   = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_W-1:0]          sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  logic              can_load;
  logic              xfer;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gidx;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   lock_ch;
  logic              lock_en;
  lock_state_e       lock_q;
  lock_state_e       lock_d;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_data[c] = in_data[c*DATA_W +: DATA_W];
  end

  assign can_load = !out_valid || out_ready;
  assign in_ready = can_load ? grant : '0;
  assign xfer     = |(in_valid & in_ready);

  if (MODE == MODE_RR) begin : g_rr
    logic unused_sel;
    assign unused_sel = ^sel;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req     (in_valid),
      .pointer (rr_ptr),
      .lock_en (lock_en),
      .lock_ch (lock_ch),
      .gnt     (grant)
    );
  end else begin : g_sel
    logic            unused_ptr;
    logic            sel_ok;
    logic [CH_W-1:0] sel_idx;

    assign unused_ptr = ^rr_ptr;

    if (NUM_CH == 1) begin : g_one
      logic unused_sel;
      assign unused_sel = ^sel;
      assign sel_ok     = 1'b1;
      assign sel_idx    = '0;
    end else begin : g_many
      assign sel_ok  = int'(sel) < NUM_CH;
      assign sel_idx = sel;
    end

    always_comb begin
      grant = '0;
      if (lock_en) begin
        if (in_valid[lock_ch]) grant[lock_ch] = 1'b1;
      end else if (sel_ok && in_valid[sel_idx]) begin
        grant[sel_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) gidx = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= LK_OPEN;
    else        lock_q <= lock_d;
  end

  always_comb begin
    lock_d = lock_q;
    if (xfer) lock_d = in_last[gidx] ? LK_OPEN : LK_PKT;
  end

  always_comb begin
    lock_en = (lock_q == LK_PKT);
  end

  // Pointer moves only on packet end so fairness is per packet, not per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_ch <= '0;
      rr_ptr  <= CH_W'(NUM_CH - 1);
    end else if (xfer) begin
      lock_ch <= gidx;
      if (in_last[gidx]) rr_ptr <= gidx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (can_load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= ch_data[gidx];
        out_last <= in_last[gidx];
        out_ch   <= gidx;
      end
    end
  end

endmodule
